ca_code_gen: RTL and testbench
==============================

Name: ca_code_gen

Overview:
- Generates the GPS L1 C/A Gold code (1023 chips, PRN 1-32) on the receiving side of the code-rate DDS.
- Consumes the DDS output MSB as the code clock: each rising edge advances the code by one chip.
- Outputs the prompt chip, the chip index, and millisecond (code epoch) and 20 ms data-bit epoch strobes for the correlator/tracking loops.
- Shares the DDS clock domain, so no synchronizer is needed.

Parameters:
CODE_LEN, 1023, chips per code period; chip_index wraps at CODE_LEN-1
MS_PER_BIT, 20, code epochs per navigation data bit
PRN_WIDTH, 6, width of prn select input

Ports:
clk  in  1  DDS/system clock (same clock driving the code DDS)
reset_n  in  1  synchronous active-low reset
code_clk  in  1  DDS output MSB (out[OUTPUT_WIDTH-1]); rising edge = one chip
enable  in  1  1 = chip ticks are honoured; 0 = state frozen, edge detector still tracks code_clk
prn  in  PRN_WIDTH  PRN number, sampled only on prn_load
prn_load  in  1  one-cycle strobe: latch prn and restart code at chip 0
chip  out  1  current prompt chip (1/0 logic level)
chip_stb  out  1  one-cycle pulse in the cycle chip/chip_index change due to a tick
chip_index  out  10  index of current chip, 0..CODE_LEN-1
epoch  out  1  one-cycle pulse when chip_index wraps CODE_LEN-1 -> 0
ms_count  out  5  epoch counter, 0..MS_PER_BIT-1
bit_epoch  out  1  one-cycle pulse when ms_count wraps MS_PER_BIT-1 -> 0 (coincident with epoch)
prn_err  out  1  latched prn outside 1..32

Behaviour:
- Reset (reset_n=0 at clk edge):
  - prn register = 1; G1 = G2 = 10'h3FF; chip_index = 0; ms_count = 0.
  - chip = 1; chip_stb = epoch = bit_epoch = prn_err = 0.
  - code_clk_d = 0; the first cycle after reset with code_clk=1 counts as an edge.
- Edge detect:
  - code_clk_d registers code_clk every cycle.
  - tick = code_clk & ~code_clk_d & enable.
- Latency: tick seen at cycle n -> chip, chip_index, chip_stb (and epoch/bit_epoch if applicable) valid at cycle n+1.
- LFSRs (stage 1..10, shift toward stage 10):
  - G1 feedback = G1[3]^G1[10].
  - G2 feedback = G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10].
  - Code value = G1[10] ^ G2[t1] ^ G2[t2], taps (t1,t2) per PRN from the package table.
  - chip is registered and computed from the next-state G1/G2 so that it matches the new chip_index.
- On tick:
  - Both LFSRs step.
  - chip_index = (chip_index == CODE_LEN-1) ? 0 : chip_index+1.
  - On wrap: G1 and G2 are forced to 10'h3FF (guards against drift), epoch=1, ms_count advances mod MS_PER_BIT.
  - bit_epoch=1 when ms_count wraps to 0.
- prn_load:
  - Latches prn; sets G1 = G2 = 3FF, chip_index = 0, ms_count = 0.
  - chip = first chip of the new PRN, which is 1 for all valid PRNs.
  - No strobes asserted.
  - prn_load wins over a coincident tick (that tick is dropped).
- Invalid PRN (0 or >32): prn_err=1 and chip held 0; counters and strobes still run.
- enable=0: no state change and no strobes. Edges occurring while disabled are lost, not queued.
- Reset mid-code takes priority over prn_load and tick.
- Consecutive ticks require at least 2 clk cycles apart; this is guaranteed by the DDS MSB.

Decomposition:
- Package ca_code_pkg:
  - CA_G2_TAP1/CA_G2_TAP2 constant arrays for PRN 1..32 (2,6; 3,7; 4,8; 5,9; 1,9; 2,10; 1,8; 2,9; 3,10; 2,3; ... per IS-GPS-200).
  - G1/G2 init constant 10'h3FF.
  - CA_CODE_LEN.
- Sub-module ca_lfsr10: 10-bit Fibonacci LFSR with step, load-all-ones, and parameterised feedback mask. Instantiated twice (G1, G2).

Test Plan:
- Reset, PRN 1, enable=1, code_clk toggling every 6 clk -> first 10 chips (index 0..9) = 1100100000 (octal 1440); chip_stb once per code_clk rising edge, 1 clk after the edge.
- prn_load with prn=2 mid-code at chip_index 500 -> chip_index=0, chip=1, first 10 chips 1110010000 (octal 1620), no epoch pulse.
- Run 1023 ticks -> epoch pulses exactly at the index 1022->0 transition; chip sequence over the second period is identical to the first (compare to a golden PRN1 model for all 1023 chips).
- Run 20x1023 ticks -> ms_count cycles 0..19; bit_epoch coincides with the 20th epoch only.
- prn=0 and prn=37 loaded -> prn_err=1, chip=0 throughout; chip_index still advances.
- Edge cases:
  - enable=0 for 3 edges -> chip_index unchanged.
  - prn_load coincident with a tick -> chip_index=0.
  - reset_n=0 coincident with prn_load -> prn reverts to 1.

Source files
------------

// File: rtl/ca_code_pkg.sv
// Shared constants for the GPS L1 C/A code generator: LFSR masks, G2 phase
// taps per PRN, and a helper that forms the C/A chip from the G1/G2 states.
package ca_code_pkg;

  localparam int CA_CODE_LEN   = 1023;
  localparam int CA_MS_PER_BIT = 20;

  localparam logic [9:0] CA_LFSR_INIT = 10'h3FF;

  // Bit i of a mask or state is LFSR stage i+1; G1 taps 3,10; G2 taps 2,3,6,8,9,10.
  localparam logic [9:0] CA_G1_MASK = 10'h204;
  localparam logic [9:0] CA_G2_MASK = 10'h3A6;

  localparam logic [3:0] CA_G2_TAP1 [32] = '{
    4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd1, 4'd2,
    4'd3, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd4,
    4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4
  };

  localparam logic [3:0] CA_G2_TAP2 [32] = '{
    4'd6,  4'd7,  4'd8,  4'd9,  4'd9,  4'd10, 4'd8,  4'd9,
    4'd10, 4'd3,  4'd4,  4'd6,  4'd7,  4'd8,  4'd9,  4'd10,
    4'd4,  4'd5,  4'd6,  4'd7,  4'd8,  4'd9,  4'd3,  4'd6,
    4'd7,  4'd8,  4'd9,  4'd10, 4'd6,  4'd7,  4'd8,  4'd9
  };

  function automatic logic prn_valid(input logic [5:0] prn);
    return (prn >= 6'd1) && (prn <= 6'd32);
  endfunction

  // Invalid PRNs force the chip to 0 rather than indexing past the tap table.
  function automatic logic ca_chip(input logic [9:0] g1, input logic [9:0] g2,
                                   input logic [5:0] prn);
    logic [4:0] idx;
    logic [3:0] t1;
    logic [3:0] t2;
    idx = 5'(prn - 6'd1);
    t1  = CA_G2_TAP1[idx] - 4'd1;
    t2  = CA_G2_TAP2[idx] - 4'd1;
    return prn_valid(prn) & (g1[9] ^ g2[t1] ^ g2[t2]);
  endfunction

endpackage

// File: rtl/ca_lfsr10.sv
// 10-stage Fibonacci LFSR shifting toward stage 10, with an all-ones restart
// that takes priority over a step.
module ca_lfsr10
  import ca_code_pkg::*;
#(
  parameter logic [9:0] MASK = CA_G1_MASK
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       load,
  output logic [9:0] state,
  output logic [9:0] stepped
);

  assign stepped = {state[8:0], ^(state & MASK)};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CA_LFSR_INIT;
    end else if (load) begin
      state <= CA_LFSR_INIT;
    end else if (step) begin
      state <= stepped;
    end
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator clocked by the code DDS MSB: one chip per rising
// edge of code_clk, with chip index, ms epoch and 20 ms data-bit epoch strobes.
module ca_code_gen
  import ca_code_pkg::*;
#(
  parameter int CODE_LEN   = CA_CODE_LEN,
  parameter int MS_PER_BIT = CA_MS_PER_BIT,
  parameter int PRN_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 code_clk,
  input  logic                 enable,
  input  logic [PRN_WIDTH-1:0] prn,
  input  logic                 prn_load,
  output logic                 chip,
  output logic                 chip_stb,
  output logic [9:0]           chip_index,
  output logic                 epoch,
  output logic [4:0]           ms_count,
  output logic                 bit_epoch,
  output logic                 prn_err
);

  localparam logic [9:0] LAST_IDX = 10'(CODE_LEN - 1);
  localparam logic [4:0] LAST_MS  = 5'(MS_PER_BIT - 1);

  logic                 code_clk_d;
  logic [PRN_WIDTH-1:0] prn_q;
  logic                 tick;
  logic                 wrap;
  logic [9:0]           g1_state;
  logic [9:0]           g2_state;
  logic [9:0]           g1_stepped;
  logic [9:0]           g2_stepped;
  logic [9:0]           g1_nxt;
  logic [9:0]           g2_nxt;

  assign tick = code_clk & ~code_clk_d & enable;
  assign wrap = (chip_index == LAST_IDX);

  // Both registers restart together on a PRN load or a code-period wrap.
  ca_lfsr10 #(.MASK(CA_G1_MASK)) u_g1 (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (tick),
    .load    (prn_load | (tick & wrap)),
    .state   (g1_state),
    .stepped (g1_stepped)
  );

  ca_lfsr10 #(.MASK(CA_G2_MASK)) u_g2 (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (tick),
    .load    (prn_load | (tick & wrap)),
    .state   (g2_state),
    .stepped (g2_stepped)
  );

  // The chip register is formed from the values the LFSRs take at this edge.
  assign g1_nxt = wrap ? CA_LFSR_INIT : g1_stepped;
  assign g2_nxt = wrap ? CA_LFSR_INIT : g2_stepped;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      code_clk_d <= 1'b0;
      prn_q      <= PRN_WIDTH'(1);
      chip_index <= '0;
      ms_count   <= '0;
      chip       <= 1'b1;
      chip_stb   <= 1'b0;
      epoch      <= 1'b0;
      bit_epoch  <= 1'b0;
      prn_err    <= 1'b0;
    end else begin
      code_clk_d <= code_clk;
      chip_stb   <= 1'b0;
      epoch      <= 1'b0;
      bit_epoch  <= 1'b0;
      if (prn_load) begin
        prn_q      <= prn;
        prn_err    <= !prn_valid(6'(prn));
        chip_index <= '0;
        ms_count   <= '0;
        chip       <= ca_chip(CA_LFSR_INIT, CA_LFSR_INIT, 6'(prn));
      end else if (tick) begin
        chip_stb   <= 1'b1;
        chip       <= ca_chip(g1_nxt, g2_nxt, 6'(prn_q));
        chip_index <= wrap ? 10'd0 : chip_index + 10'd1;
        if (wrap) begin
          epoch     <= 1'b1;
          ms_count  <= (ms_count == LAST_MS) ? 5'd0 : ms_count + 5'd1;
          bit_epoch <= (ms_count == LAST_MS);
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_code_gen.sv
// Directed self-checking bench for ca_code_gen with an independent stage-array
// model of the PRN 1 Gold code.
module tb_ca_code_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       code_clk;
  logic       enable;
  logic [5:0] prn;
  logic       prn_load;
  logic       chip;
  logic       chip_stb;
  logic [9:0] chip_index;
  logic       epoch;
  logic [4:0] ms_count;
  logic       bit_epoch;
  logic       prn_err;

  int   checks = 0;
  int   errors = 0;
  logic gold [1023];
  logic stb_high, stb_low, ep_seen, bep_seen;

  ca_code_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_clk   (code_clk),
    .enable     (enable),
    .prn        (prn),
    .prn_load   (prn_load),
    .chip       (chip),
    .chip_stb   (chip_stb),
    .chip_index (chip_index),
    .epoch      (epoch),
    .ms_count   (ms_count),
    .bit_epoch  (bit_epoch),
    .prn_err    (prn_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full code_clk period; strobes are sampled one clk after the rising edge.
  task automatic applyStimulus(input int half);
    code_clk = 1'b1;
    @(negedge clk);
    stb_high = chip_stb;
    ep_seen  = epoch;
    bep_seen = bit_epoch;
    repeat (half - 1) @(negedge clk);
    code_clk = 1'b0;
    repeat (half) @(negedge clk);
    stb_low = chip_stb;
  endtask

  task automatic loadPrn(input logic [5:0] p);
    prn      = p;
    prn_load = 1'b1;
    @(negedge clk);
    prn_load = 1'b0;
  endtask

  task automatic genGold(input int t1, input int t2);
    int g1 [1:10];
    int g2 [1:10];
    int f1, f2;
    for (int k = 1; k <= 10; k++) begin
      g1[k] = 1;
      g2[k] = 1;
    end
    for (int n = 0; n < 1023; n++) begin
      gold[n] = logic'(g1[10] ^ g2[t1] ^ g2[t2]);
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int k = 10; k >= 2; k--) begin
        g1[k] = g1[k-1];
        g2[k] = g2[k-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  task automatic collectTen(input int half, output logic [9:0] pat, output int ep_count);
    ep_count = 0;
    pat[9] = chip;
    for (int i = 1; i < 10; i++) begin
      applyStimulus(half);
      pat[9-i] = chip;
      ep_count += int'(ep_seen);
    end
  endtask

  initial begin
    logic [9:0] pat;
    int bad_chip, bad_idx, bad_stb, bad_ep, eps, exp_idx;
    int exp_ms, bad_ms, bad_bep, bits, nonzero, stb_count;

    genGold(2, 6);
    reset_n  = 1'b0;
    code_clk = 1'b0;
    enable   = 1'b1;
    prn      = 6'd0;
    prn_load = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("reset chip", chip, 1);
    checkOutput("reset chip_index", chip_index, 0);
    checkOutput("reset ms_count", ms_count, 0);
    checkOutput("reset strobes", {chip_stb, epoch, bit_epoch}, 0);
    checkOutput("reset prn_err", prn_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    stb_count = 0;
    pat[9] = chip;
    for (int i = 1; i < 10; i++) begin
      applyStimulus(6);
      pat[9-i] = chip;
      if (stb_high && !stb_low) stb_count++;
    end
    checkOutput("prn1 first ten chips", pat, 10'b1100100000);
    checkOutput("prn1 chip_stb per edge", stb_count, 9);
    checkOutput("prn1 index after 9 ticks", chip_index, 9);

    bad_chip = 0; bad_idx = 0; bad_stb = 0;
    for (int k = 10; k <= 500; k++) begin
      applyStimulus(1);
      if (chip !== gold[k]) bad_chip++;
      if (chip_index != 10'(k)) bad_idx++;
      if (!(stb_high && !stb_low)) bad_stb++;
    end
    checkOutput("prn1 chips 10..500", bad_chip, 0);
    checkOutput("prn1 index 10..500", bad_idx, 0);
    checkOutput("prn1 stb 10..500", bad_stb, 0);

    loadPrn(6'd2);
    checkOutput("prn2 load index", chip_index, 0);
    checkOutput("prn2 load chip", chip, 1);
    checkOutput("prn2 load strobes", {chip_stb, epoch, bit_epoch}, 0);
    collectTen(1, pat, eps);
    checkOutput("prn2 first ten chips", pat, 10'b1110010000);
    checkOutput("prn2 no epoch", eps, 0);

    loadPrn(6'd1);
    checkOutput("prn1 reload chip0", chip, gold[0]);
    bad_chip = 0; bad_idx = 0; bad_ep = 0; eps = 0;
    for (int n = 1; n <= 2046; n++) begin
      applyStimulus(1);
      exp_idx = n % 1023;
      if (chip_index != 10'(exp_idx)) bad_idx++;
      if (chip !== gold[exp_idx]) bad_chip++;
      if (ep_seen != (exp_idx == 0)) bad_ep++;
      eps += int'(ep_seen);
    end
    checkOutput("two periods chips", bad_chip, 0);
    checkOutput("two periods index", bad_idx, 0);
    checkOutput("epoch placement", bad_ep, 0);
    checkOutput("epoch count", eps, 2);
    checkOutput("ms_count after 2 periods", ms_count, 2);

    loadPrn(6'd1);
    checkOutput("reload ms_count", ms_count, 0);
    exp_ms = 0; bad_ms = 0; bad_bep = 0; bits = 0;
    for (int n = 1; n <= 20 * 1023; n++) begin
      applyStimulus(1);
      if (ep_seen) exp_ms = (exp_ms + 1) % 20;
      if (bep_seen != (ep_seen && exp_ms == 0)) bad_bep++;
      bits += int'(bep_seen);
      if (ms_count != 5'(exp_ms)) bad_ms++;
    end
    checkOutput("ms_count sequence", bad_ms, 0);
    checkOutput("bit_epoch placement", bad_bep, 0);
    checkOutput("bit_epoch count", bits, 1);
    checkOutput("ms_count after 20 periods", ms_count, 0);

    loadPrn(6'd0);
    checkOutput("prn0 prn_err", prn_err, 1);
    checkOutput("prn0 chip", chip, 0);
    nonzero = 0;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(1);
      if (chip !== 1'b0) nonzero++;
    end
    checkOutput("prn0 chip held", nonzero, 0);
    checkOutput("prn0 index runs", chip_index, 30);

    loadPrn(6'd37);
    checkOutput("prn37 prn_err", prn_err, 1);
    nonzero = int'(chip);
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1);
      if (chip !== 1'b0) nonzero++;
    end
    checkOutput("prn37 chip held", nonzero, 0);
    checkOutput("prn37 index runs", chip_index, 10);

    loadPrn(6'd1);
    checkOutput("valid prn clears prn_err", prn_err, 0);
    for (int n = 0; n < 5; n++) applyStimulus(1);
    enable = 1'b0;
    stb_count = 0;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(3);
      stb_count += int'(stb_high);
    end
    checkOutput("disabled index frozen", chip_index, 5);
    checkOutput("disabled no stb", stb_count, 0);
    enable = 1'b1;
    applyStimulus(1);
    checkOutput("re-enabled index", chip_index, 6);
    checkOutput("re-enabled chip", chip, gold[6]);

    code_clk = 1'b1;
    prn      = 6'd1;
    prn_load = 1'b1;
    @(negedge clk);
    prn_load = 1'b0;
    checkOutput("load beats tick index", chip_index, 0);
    checkOutput("load beats tick stb", chip_stb, 0);
    code_clk = 1'b0;
    repeat (2) @(negedge clk);

    loadPrn(6'd37);
    checkOutput("pre-reset prn_err", prn_err, 1);
    reset_n  = 1'b0;
    prn      = 6'd2;
    prn_load = 1'b1;
    @(negedge clk);
    reset_n  = 1'b1;
    prn_load = 1'b0;
    checkOutput("reset beats load prn_err", prn_err, 0);
    checkOutput("reset beats load index", chip_index, 0);
    collectTen(1, pat, eps);
    checkOutput("reset reverts to prn1", pat, 10'b1100100000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
